rr_capture_arbiter: RTL and testbench
=====================================

Name: rr_capture_arbiter

Overview:
Shares one registered capture stage (input sample -> registered output) between NREQ requesters.
- Picks one pending requester per cycle in round-robin order and latches its data into the output register.
- Presents the latched data downstream with a valid/ready handshake.
- Sits in front of the existing registered output path; it is the scheduler that decides whose sample is captured each cycle.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, data width per requester.
- SRCW, clog2(NREQ) (min 1), width of source index; derived, not overridden.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_enable  input  NREQ  per-requester enable mask; a masked requester is never granted.
- req  input  NREQ  request per requester; must stay high with stable data until granted.
- req_data  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot, combinational; gnt[i]=1 in the cycle requester i's data is captured.
- out_valid  output  1  output register holds unconsumed data.
- out_data  output  WIDTH  captured data.
- out_src  output  SRCW  index of the requester that owns out_data.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset, synchronous and sampled on the clock edge:
  - out_valid=0, out_data=0, out_src=0.
  - last-grant pointer = NREQ-1, so requester 0 has first priority.
  - state=EMPTY.
  - gnt=0 whenever reset is high.
- Eligible set: elig = req & cfg_enable.
- load condition: any(elig) && (state==EMPTY || out_ready). This makes the stage drain-and-refill capable at 1 transfer/cycle.
- Selection: first set bit of elig searching from (ptr+1) mod NREQ upward, with wrap-around.
- On a load:
  - gnt[sel]=1 in that cycle, all other gnt bits 0.
  - At the clock edge: out_data<=req_data[sel], out_src<=sel, out_valid<=1, ptr<=sel.
- No load: gnt=0 and ptr is unchanged.
- State machine:
  - EMPTY: out_valid=0. On load -> FULL.
  - FULL: out_valid=1.
    - out_ready=0: hold out_data and out_src stable and keep gnt=0.
    - out_ready=1 and load: stay FULL with the new data (back-to-back).
    - out_ready=1 and no load: -> EMPTY, out_valid<=0, out_data keeps its last value.
- Latency: 1 cycle from gnt to out_valid/out_data visible.
- Fairness: a continuously requesting, enabled requester waits at most NREQ-1 transfers.
- cfg_enable changes take effect the same cycle. Clearing a bit never affects data already captured.
- A single eligible requester that requests continuously is granted every transfer cycle.
- Reset mid-transfer: captured data is discarded, with out_valid=0 the cycle after reset is sampled. gnt is forced 0 during reset, so no requester sees a grant that gets dropped.
- Out-of-range sel is unreachable; any ptr value >= NREQ is treated as NREQ-1.

Decomposition:
- Shared package holds:
  - the clog2 function used for SRCW;
  - the state encoding constants (ST_EMPTY=0, ST_FULL=1).
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: elig[NREQ], ptr[SRCW].
  - Outputs: any, sel[SRCW], onehot[NREQ].
- The top holds the state register, pointer, output register and handshake logic.

Test Plan:
- Reset check: hold reset 2 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_data=0, out_src=0; first load after reset grants requester 0.
- Round-robin: NREQ=4, cfg_enable=4'hF, req=4'b1111, data i=8'h10+i, out_ready=1 -> gnt sequence 0001,0010,0100,1000,0001; out_data 10,11,12,13 on consecutive cycles one cycle later.
- Backpressure: req=4'b0101, out_ready=0 after first capture -> out_valid=1, out_data=8'h10 held, gnt=0; then out_ready=1 -> gnt=0100 that cycle, out_data=8'h12, out_src=2 next cycle.
- Masking and wrap: cfg_enable=4'b1001, req=4'b1111, ptr=0 -> grants 3,0,3,0; requesters 1 and 2 are never granted.
- Drain to empty: single req[2] pulse (held until gnt) with out_ready=1 -> one capture, out_valid high exactly 1 cycle, then EMPTY with out_data=8'h12 retained.
- Reset mid-operation: assert reset while FULL with out_ready=0 -> out_valid=0 next cycle; after release with req=4'b1000, first grant is requester 3 and ptr restarts from NREQ-1.

Source files
------------

// File: rtl/rr_capture_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_capture_arbiter_pkg
//   Shared definitions for the round-robin capture arbiter:
//     - state_e    : capture-stage state encoding (ST_EMPTY=0, ST_FULL=1)
//     - clog2_min1 : ceil(log2(n)) clamped to at least 1, used to size the
//                    requester index so a 2-requester build still has a
//                    1-bit source field.
// ---------------------------------------------------------------------------
package rr_capture_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_capture_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_capture_arbiter_pick (module rr_pick)
//   Combinational rotate-priority encoder. Finds the first set bit of elig
//   searching upward from (ptr+1) mod NREQ, wrapping around, so the most
//   recently granted requester has the lowest priority.
//
//   Ports:
//     elig   in  NREQ  eligible requesters (req & cfg_enable)
//     ptr    in  SRCW  index of the last granted requester
//     any    out 1     at least one eligible requester
//     sel    out SRCW  index of the selected requester (0 when none)
//     onehot out NREQ  one-hot form of sel (all zero when none)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [SRCW-1:0] ptr,
  output logic            any,
  output logic [SRCW-1:0] sel,
  output logic [NREQ-1:0] onehot
);

  int               base;
  int               idx;
  logic [SRCW-1:0]  idx_s;

  always_comb begin
    any    = 1'b0;
    sel    = '0;
    onehot = '0;
    idx    = 0;
    idx_s  = '0;
    // A pointer outside the requester range cannot occur in normal
    // operation; fold it onto the last index so requester 0 leads.
    base   = (int'(ptr) >= NREQ) ? (NREQ - 1) : int'(ptr);
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (base + k) % NREQ;
      idx_s = SRCW'(idx);
      if (!any && elig[idx_s]) begin
        any           = 1'b1;
        sel           = idx_s;
        onehot[idx_s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_capture_arbiter.sv
// ---------------------------------------------------------------------------
// rr_capture_arbiter
//   Shares one registered capture stage between NREQ requesters. Each cycle
//   the stage can accept data, one eligible requester is picked in
//   round-robin order, granted combinationally, and its sample is latched
//   into the output register, which is then offered downstream through a
//   valid/ready handshake. A full stage that is being drained can refill in
//   the same cycle, so the stage sustains one transfer per cycle.
//
//   Ports:
//     clock      in  1           rising-edge clock
//     reset      in  1           synchronous active-high reset
//     cfg_enable in  NREQ        per-requester enable mask
//     req        in  NREQ        request per requester (held until granted)
//     req_data   in  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
//     gnt        out NREQ        one-hot grant, combinational
//     out_valid  out 1           output register holds unconsumed data
//     out_data   out WIDTH       captured data
//     out_src    out SRCW        requester index owning out_data
//     out_ready  in  1           downstream accepts when out_valid && out_ready
// ---------------------------------------------------------------------------
module rr_capture_arbiter
  import rr_capture_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int SRCW  = clog2_min1(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       cfg_enable,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_ready
);

  state_e            state_q, state_d;
  logic [SRCW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SRCW-1:0]   src_q, src_d;

  logic [NREQ-1:0]   elig;
  logic              pick_any;
  logic [SRCW-1:0]   pick_sel;
  logic [NREQ-1:0]   pick_onehot;
  logic              load;
  logic [WIDTH-1:0]  cap_data;

  assign elig = req & cfg_enable;

  rr_pick #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .any    (pick_any),
    .sel    (pick_sel),
    .onehot (pick_onehot)
  );

  // The stage can take new data when empty, or when the current word is
  // leaving this cycle. Reset suppresses the load so no requester ever
  // observes a grant whose data is then thrown away.
  assign load = pick_any && ((state_q == ST_EMPTY) || out_ready) && !reset;
  assign gnt  = load ? pick_onehot : '0;

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel == SRCW'(i)) begin
        cap_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      state_d = ST_FULL;
      ptr_d   = pick_sel;
      data_d  = cap_data;
      src_d   = pick_sel;
    end else if ((state_q == ST_FULL) && out_ready) begin
      // Drained with nothing to refill: data is kept, only valid drops.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= SRCW'(NREQ - 1);
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_capture_arbiter.sv
module tb_rr_capture_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  cfg_enable;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  rr_capture_arbiter #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_enable (cfg_enable),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks run 1 time unit
  // later, well away from the rising edge that samples them.
  task automatic cyc(input logic rst, input logic [3:0] en, input logic [3:0] rq, input logic rdy);
    @(negedge clock);
    reset      = rst;
    cfg_enable = en;
    req        = rq;
    out_ready  = rdy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                         input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".gnt"},   32'(gnt),       32'(g));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".src"},   32'(out_src),   32'(s));
  endtask

  initial begin
    reset      = 1'b1;
    cfg_enable = 4'hF;
    req        = 4'b1111;
    req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready  = 1'b1;

    // Reset held two cycles with all requesters active
    cyc(1'b1, 4'hF, 4'b1111, 1'b1);
    chk("rst1.gnt", 32'(gnt), 32'h0);
    cyc(1'b1, 4'hF, 4'b1111, 1'b1);
    chk_out("rst2", 4'b0000, 1'b0, 8'h00, 2'd0);

    // Round-robin over all four, one transfer per cycle
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("rr0", 4'b0001, 1'b0, 8'h00, 2'd0);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("rr1", 4'b0010, 1'b1, 8'h10, 2'd0);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("rr2", 4'b0100, 1'b1, 8'h11, 2'd1);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("rr3", 4'b1000, 1'b1, 8'h12, 2'd2);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("rr4", 4'b0001, 1'b1, 8'h13, 2'd3);

    // Backpressure: stage full with 0x10, downstream stalls
    cyc(1'b0, 4'hF, 4'b0101, 1'b0);
    chk_out("bp0", 4'b0000, 1'b1, 8'h10, 2'd0);
    cyc(1'b0, 4'hF, 4'b0101, 1'b0);
    chk_out("bp1", 4'b0000, 1'b1, 8'h10, 2'd0);
    cyc(1'b0, 4'hF, 4'b0101, 1'b1);
    chk_out("bp2", 4'b0100, 1'b1, 8'h10, 2'd0);

    // Masking: only requesters 3 and 0 enabled, they alternate
    cyc(1'b0, 4'b1001, 4'b1111, 1'b1);
    chk_out("mk0", 4'b1000, 1'b1, 8'h12, 2'd2);
    cyc(1'b0, 4'b1001, 4'b1111, 1'b1);
    chk_out("mk1", 4'b0001, 1'b1, 8'h13, 2'd3);
    cyc(1'b0, 4'b1001, 4'b1111, 1'b1);
    chk_out("mk2", 4'b1000, 1'b1, 8'h10, 2'd0);
    cyc(1'b0, 4'b1001, 4'b1111, 1'b1);
    chk_out("mk3", 4'b0001, 1'b1, 8'h13, 2'd3);

    // Drain: one pulse on requester 2, then the stage empties
    cyc(1'b0, 4'hF, 4'b0100, 1'b1);
    chk_out("dr0", 4'b0100, 1'b1, 8'h10, 2'd0);
    cyc(1'b0, 4'hF, 4'b0000, 1'b1);
    chk_out("dr1", 4'b0000, 1'b1, 8'h12, 2'd2);
    cyc(1'b0, 4'hF, 4'b0000, 1'b1);
    chk_out("dr2", 4'b0000, 1'b0, 8'h12, 2'd2);

    // Fill from empty while downstream is stalled
    cyc(1'b0, 4'hF, 4'b0001, 1'b0);
    chk_out("fl0", 4'b0001, 1'b0, 8'h12, 2'd2);
    cyc(1'b0, 4'hF, 4'b0001, 1'b0);
    chk_out("fl1", 4'b0000, 1'b1, 8'h10, 2'd0);

    // Reset while full: a load would otherwise happen, gnt must stay 0
    cyc(1'b1, 4'hF, 4'b0001, 1'b1);
    chk_out("mr0", 4'b0000, 1'b1, 8'h10, 2'd0);

    // After reset the pointer is back at 3
    cyc(1'b0, 4'hF, 4'b1000, 1'b1);
    chk_out("mr1", 4'b1000, 1'b0, 8'h00, 2'd0);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("mr2", 4'b0001, 1'b1, 8'h13, 2'd3);
    cyc(1'b0, 4'hF, 4'b1111, 1'b1);
    chk_out("mr3", 4'b0010, 1'b1, 8'h10, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
